// File: rtl/dino_game_pkg.sv
// Shared Dino game definitions: screen bounds, byte/colour types and the
// frame scheduler state encoding.
package dino_game_pkg;

  localparam int X_MAX_DEF = 159;
  localparam int Y_MAX_DEF = 119;

  typedef logic [7:0] ubyte;
  typedef logic [2:0] color_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/dino_raster_counter.sv
// Raster x/y counter, x fastest; 'last' flags the final coordinate of a screen.
module dino_raster_counter
  import dino_game_pkg::*;
#(
  parameter int X_MAX = X_MAX_DEF,
  parameter int Y_MAX = Y_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic step,
  output ubyte x,
  output ubyte y,
  output logic last
);

  assign last = (x == 8'(X_MAX)) && (y == 8'(Y_MAX));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (x == 8'(X_MAX)) begin
        x <= '0;
        y <= (y == 8'(Y_MAX)) ? 8'd0 : y + 8'd1;
      end else begin
        x <= x + 8'd1;
      end
    end
  end

endmodule

// File: rtl/dino_frame_scheduler.sv
// Per-frame render pass sequencer: snapshot, raster scan, shade pipeline and
// overlay arbitration. DINO_OVERRUN_CNT_EN builds the dropped-tick counter.
module dino_frame_scheduler
  import dino_game_pkg::*;
#(
  parameter int X_MAX = X_MAX_DEF,
  parameter int Y_MAX = Y_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [3:0] game_state,
  input  logic [7:0] dino_y,
  input  logic [7:0] obs1_x,
  input  logic [7:0] obs1_h,
  input  logic [7:0] obs2_x,
  input  logic [7:0] obs2_h,
  output logic [3:0] snap_state,
  output logic [7:0] snap_dino_y,
  output logic [7:0] snap_obs1_x,
  output logic [7:0] snap_obs1_h,
  output logic [7:0] snap_obs2_x,
  output logic [7:0] snap_obs2_h,
  output logic [7:0] scan_x,
  output logic [7:0] scan_y,
  output logic       scan_valid,
  input  logic [2:0] shade_color,
  input  logic       ovl_req,
  input  logic [7:0] ovl_x,
  input  logic [7:0] ovl_y,
  input  logic [2:0] ovl_color,
  output logic       ovl_ack,
  output logic [7:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_color,
  output logic       vga_plot,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] overrun_cnt
);

  sched_state_t state;
  logic pending, start, drain_cnt, d_valid, last;
  ubyte d_x, d_y;

  assign start   = (state == S_IDLE) && enable && (frame_tick || pending);
  // A starting pass owns the plot port, so the overlay waits that cycle.
  assign ovl_ack = (state == S_IDLE) && ovl_req && !start;

  dino_raster_counter #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_raster (
    .clk   (clk),
    .reset (reset),
    .clear (state == S_LATCH),
    .step  (state == S_SCAN),
    .x     (scan_x),
    .y     (scan_y),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pending     <= 1'b0;
      drain_cnt   <= 1'b0;
      scan_valid  <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      snap_state  <= '0;
      snap_dino_y <= '0;
      snap_obs1_x <= '0;
      snap_obs1_h <= '0;
      snap_obs2_x <= '0;
      snap_obs2_h <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_LATCH;
          busy  <= 1'b1;
        end
        S_LATCH: begin
          snap_state  <= game_state;
          snap_dino_y <= dino_y;
          snap_obs1_x <= obs1_x;
          snap_obs1_h <= obs1_h;
          snap_obs2_x <= obs2_x;
          snap_obs2_h <= obs2_h;
          scan_valid  <= 1'b1;
          state       <= S_SCAN;
        end
        S_SCAN: if (last) begin
          scan_valid <= 1'b0;
          drain_cnt  <= 1'b0;
          state      <= S_DRAIN;
        end
        S_DRAIN: if (drain_cnt) begin
          busy       <= 1'b0;
          frame_done <= 1'b1;
          state      <= S_DONE;
        end else begin
          drain_cnt <= 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // LATCH consumes the pending request; a tick landing in LATCH re-arms it.
      if (state == S_LATCH) pending <= frame_tick;
      else if (frame_tick && !start) pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_valid   <= 1'b0;
      d_x       <= '0;
      d_y       <= '0;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= '0;
      vga_plot  <= 1'b0;
    end else begin
      d_valid <= scan_valid;
      d_x     <= scan_x;
      d_y     <= scan_y;
      if (d_valid) begin
        vga_x     <= d_x;
        vga_y     <= d_y;
        vga_color <= shade_color;
        vga_plot  <= 1'b1;
      end else if (ovl_ack) begin
        vga_x     <= ovl_x;
        vga_y     <= ovl_y;
        vga_color <= ovl_color;
        vga_plot  <= 1'b1;
      end else begin
        vga_plot <= 1'b0;
      end
    end
  end

`ifdef DINO_OVERRUN_CNT_EN
  logic drop;
  assign drop = frame_tick && pending && (state != S_IDLE) && (state != S_LATCH);

  always_ff @(posedge clk) begin
    if (reset) overrun_cnt <= '0;
    else if (drop && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
  end
`else
  assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_dino_frame_scheduler.sv
// Self-checking bench for dino_frame_scheduler: IDLE vector table, full-pass
// raster/timing model, overrun, overlay, mid-pass reset and enable gating.
module tb_dino_frame_scheduler;

  localparam int XM   = 159;
  localparam int YM   = 119;
  localparam int NPIX = (XM + 1) * (YM + 1);

  logic clk = 0, reset = 1, enable = 0, frame_tick = 0;
  logic [3:0] game_state = 0;
  logic [7:0] dino_y = 0, obs1_x = 0, obs1_h = 0, obs2_x = 0, obs2_h = 0;
  logic [3:0] snap_state;
  logic [7:0] snap_dino_y, snap_obs1_x, snap_obs1_h, snap_obs2_x, snap_obs2_h;
  logic [7:0] scan_x, scan_y;
  logic       scan_valid;
  logic [2:0] shade_color = 0;
  logic       ovl_req = 0;
  logic [7:0] ovl_x = 0, ovl_y = 0;
  logic [2:0] ovl_color = 0;
  logic       ovl_ack;
  logic [7:0] vga_x, vga_y;
  logic [2:0] vga_color;
  logic       vga_plot, busy, frame_done;
  logic [7:0] overrun_cnt;

  dino_frame_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick),
    .game_state(game_state), .dino_y(dino_y), .obs1_x(obs1_x), .obs1_h(obs1_h),
    .obs2_x(obs2_x), .obs2_h(obs2_h),
    .snap_state(snap_state), .snap_dino_y(snap_dino_y), .snap_obs1_x(snap_obs1_x),
    .snap_obs1_h(snap_obs1_h), .snap_obs2_x(snap_obs2_x), .snap_obs2_h(snap_obs2_h),
    .scan_x(scan_x), .scan_y(scan_y), .scan_valid(scan_valid),
    .shade_color(shade_color),
    .ovl_req(ovl_req), .ovl_x(ovl_x), .ovl_y(ovl_y), .ovl_color(ovl_color),
    .ovl_ack(ovl_ack),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot),
    .busy(busy), .frame_done(frame_done), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Shader model: colour is a function of the coordinate and a per-pass salt.
  logic [2:0] salt = 0, next_salt = 0;
  function automatic logic [2:0] shade_fn(input logic [7:0] x, input logic [7:0] y, input logic [2:0] s);
    return x[2:0] ^ (s & y[2:0]);
  endfunction
  always @(posedge clk) shade_color <= shade_fn(scan_x, scan_y, salt);

  // Monitor: plot k of a pass must be pixel (k mod W, k div W) with its shade.
  logic        mon_on = 0, ovl_mode = 0, prev_busy = 0;
  logic [43:0] lat_pack = 0;
  int pix_k = 0, bad_pix = 0, gap = 0, snap_bad = 0, ack_bad = 0;
  int first_plot = -1, last_plot = 0, n_done = 0, ex, ey;
  int done_cyc[4], plots[4];

  wire [43:0] live_pack = {game_state, dino_y, obs1_x, obs1_h, obs2_x, obs2_h};
  wire [43:0] snap_pack = {snap_state, snap_dino_y, snap_obs1_x, snap_obs1_h, snap_obs2_x, snap_obs2_h};

  always @(negedge clk) if (mon_on) begin
    if (vga_plot && !ovl_mode) begin
      ex = pix_k % (XM + 1);
      ey = pix_k / (XM + 1);
      if (vga_x != 8'(ex) || vga_y != 8'(ey) || vga_color != shade_fn(8'(ex), 8'(ey), salt))
        bad_pix++;
      if (pix_k == 0) first_plot = cyc;
      else if (last_plot != cyc - 1) gap++;
      last_plot = cyc;
      pix_k++;
    end
    if (busy && !prev_busy) lat_pack = live_pack;
    if (scan_valid && snap_pack != lat_pack) snap_bad++;
    if (ovl_ack && busy) ack_bad++;
    if (frame_done && n_done < 4) begin
      done_cyc[n_done] = cyc;
      plots[n_done]    = pix_k;
      n_done++;
      pix_k = 0;
      salt  = next_salt;
    end
    prev_busy = busy;
  end

  task automatic clear_mon();
    pix_k = 0; bad_pix = 0; gap = 0; snap_bad = 0; ack_bad = 0;
    first_plot = -1; prev_busy = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1;
    @(posedge clk);
    @(posedge clk); #1 reset = 0;
  endtask

  task automatic rand_live();
    game_state = 4'($urandom);
    obs1_x = 8'($urandom); obs1_h = 8'($urandom);
    obs2_x = 8'($urandom); obs2_h = 8'($urandom);
  endtask

  typedef struct {
    logic en, tick, req;
    logic [7:0] x, y;
    logic [2:0] c;
    logic exp_ack, exp_plot, exp_busy;
  } vec_t;
  vec_t vt[5];

  int T, T3, nb, exp_ovr;
  logic found;

  initial begin
    // IDLE vectors: overlay grant, enable/tick interplay with no pass start.
    vt[0] = '{en:0, tick:0, req:1, x:0, y:0, c:0, exp_ack:1, exp_plot:1, exp_busy:0};
    vt[1] = '{en:0, tick:0, req:0, x:0, y:0, c:0, exp_ack:0, exp_plot:0, exp_busy:0};
    vt[2] = '{en:1, tick:0, req:1, x:0, y:0, c:0, exp_ack:1, exp_plot:1, exp_busy:0};
    vt[3] = '{en:0, tick:1, req:1, x:0, y:0, c:0, exp_ack:1, exp_plot:1, exp_busy:0};
    vt[4] = '{en:0, tick:0, req:1, x:0, y:0, c:0, exp_ack:1, exp_plot:1, exp_busy:0};
    for (int i = 0; i < 5; i++) begin
      vt[i].x = 8'($urandom_range(0, XM));
      vt[i].y = 8'($urandom_range(0, YM));
      vt[i].c = 3'($urandom);
    end
`ifdef DINO_OVERRUN_CNT_EN
    exp_ovr = 2;
`else
    exp_ovr = 0;
`endif

    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_scan_valid", scan_valid, 0);
    check("rst_vga_plot", vga_plot, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun_cnt, 0);
    check("rst_snap", snap_pack, 0);
    check("rst_scan_xy", {scan_x, scan_y}, 0);
    check("rst_vga", {vga_x, vga_y, vga_color}, 0);
    check("rst_ovl_ack", ovl_ack, 0);

    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      enable = vt[i].en; frame_tick = vt[i].tick; ovl_req = vt[i].req;
      ovl_x = vt[i].x; ovl_y = vt[i].y; ovl_color = vt[i].c;
      @(negedge clk);
      check($sformatf("vec%0d_ack", i), ovl_ack, vt[i].exp_ack);
      @(posedge clk); #1;
      enable = 0; frame_tick = 0; ovl_req = 0;
      @(negedge clk);
      check($sformatf("vec%0d_plot", i), vga_plot, vt[i].exp_plot);
      if (vt[i].exp_plot) check($sformatf("vec%0d_pix", i), {vga_x, vga_y, vga_color}, {vt[i].x, vt[i].y, vt[i].c});
      check($sformatf("vec%0d_busy", i), busy, vt[i].exp_busy);
    end

    // Enable gating: tick from vec3 is pending; pass starts only once enable rises.
    nb = 0;
    repeat (20) begin @(negedge clk); if (busy) nb++; end
    check("gate_hold_idle", nb, 0);
    @(posedge clk); #1 enable = 1; ovl_req = 1;
    @(negedge clk);
    check("gate_no_ack_on_start", ovl_ack, 0);
    check("gate_still_idle", busy, 0);
    @(posedge clk); #1 ovl_req = 0;
    @(negedge clk);
    check("gate_latch_busy", busy, 1);
    check("gate_latch_no_scan", scan_valid, 0);
    @(negedge clk);
    check("gate_scan_start", {scan_valid, scan_x, scan_y}, {1'b1, 16'h0});
    enable = 0;
    do_reset();

    // Pass 1 + pass 2: timing, raster content, snapshot, overrun, overlay hold.
    clear_mon();
    salt = 0; next_salt = 3'($urandom_range(1, 7));
    rand_live(); dino_y = 50; enable = 1; mon_on = 1;
    @(posedge clk); #1 frame_tick = 1; T = cyc;
    @(posedge clk); #1 frame_tick = 0;
    repeat (100) @(posedge clk);
    #1 dino_y = 80; rand_live();
    ovl_req = 1; ovl_x = 8'($urandom_range(0, XM)); ovl_y = 8'($urandom_range(0, YM)); ovl_color = 3'($urandom);
    repeat (200) @(posedge clk); #1 enable = 0;
    repeat (50) @(posedge clk); #1 enable = 1;
    repeat (3) begin
      repeat (1000) @(posedge clk);
      #1 frame_tick = 1;
      @(posedge clk); #1 frame_tick = 0;
    end

    for (int i = 0; i < 20000 && n_done < 1; i++) @(posedge clk);
    check("p1_done_seen", n_done, 1);
    check("p1_first_plot_cyc", first_plot - T, 4);
    check("p1_done_cyc", done_cyc[0] - T, 19204);
    check("p1_plot_count", plots[0], NPIX);
    check("p1_pixels", bad_pix, 0);
    check("p1_snap_dino_y", snap_dino_y, 50);

    for (int i = 0; i < 20000 && n_done < 2; i++) @(posedge clk);
    #1 ovl_mode = 1;
    check("p2_done_seen", n_done, 2);
    check("p2_back_to_back", done_cyc[1] - done_cyc[0], 19205);
    check("p2_plot_count", plots[1], NPIX);
    check("p12_pixels", bad_pix, 0);
    check("p12_plot_gaps", gap, 0);
    check("p12_snap_stable", snap_bad, 0);
    check("p2_snap_dino_y", snap_dino_y, 80);
    check("ack_while_busy", ack_bad, 0);
    check("overrun_cnt", overrun_cnt, exp_ovr);

    // Overlay held through the pass is granted in the first free IDLE cycle.
    @(negedge clk);
    check("ovl_idle_cycle", cyc - done_cyc[1], 1);
    check("ovl_ack_idle", ovl_ack, 1);
    @(posedge clk); #1 ovl_req = 0;
    @(negedge clk);
    check("ovl_plot", {vga_plot, vga_x, vga_y, vga_color}, {1'b1, ovl_x, ovl_y, ovl_color});
    @(negedge clk);
    check("ovl_plot_end", vga_plot, 0);
    ovl_mode = 0;

    // Mid-pass reset at issue 5000 (x=40,y=31).
    clear_mon();
    salt = 3'($urandom); next_salt = salt;
    rand_live(); dino_y = 8'($urandom);
    @(posedge clk); #1 frame_tick = 1;
    @(posedge clk); #1 frame_tick = 0;
    found = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (scan_valid && scan_x == 8'd40 && scan_y == 8'd31) begin found = 1; break; end
    end
    check("mid_issue5000_found", found, 1);
    reset = 1;
    @(posedge clk); #1 reset = 0;
    nb = 0;
    repeat (30) begin @(negedge clk); if (vga_plot || frame_done || busy) nb++; end
    check("mid_quiet_after_reset", nb, 0);
    check("mid_plots_before_reset", pix_k, 4999);
    check("mid_pixels", bad_pix, 0);
    check("mid_no_done", n_done, 2);
    check("mid_overrun_cleared", overrun_cnt, 0);

    // Fresh tick restarts from (0,0).
    clear_mon();
    @(posedge clk); #1 frame_tick = 1; T3 = cyc;
    @(posedge clk); #1 frame_tick = 0;
    repeat (300) @(posedge clk);
    check("restart_first_plot", first_plot - T3, 4);
    check("restart_pixels", bad_pix, 0);
    check("restart_progress", pix_k > 250, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
